// File: rtl/preemption_timer.sv
// -----------------------------------------------------------------------------
// preemption_timer
//   Memory-mapped cycle timer that raises a single-cycle trap request
//   (timerInterrupt) each time COUNT matches COMPARE. Further requests are
//   masked until the handler returns (isReturn).
//
//   Register window (16 bytes at BASE_ADDRESS, word select address[3:2]):
//     0x0 CONTROL  bit0 enable, bit1 autoReload
//     0x4 COUNT    free-running counter
//     0x8 COMPARE  match value
//     0xC STATUS   bit0 pending (write-1-to-clear), bit1 inHandler (RO)
//
//   Ports:
//     clk               system clock, rising edge
//     reset             asynchronous active-high reset
//     address           byte address from the data bus
//     writeData         store data
//     memoryWriteEnable store strobe
//     isReturn          MRET decode, ends handler masking
//     readData          combinational load data (0 outside the window)
//     timerInterrupt    registered one-cycle trap request
// -----------------------------------------------------------------------------
module preemption_timer #(
   parameter logic [31:0] BASE_ADDRESS    = 32'hFFFF_0100,
   parameter logic [31:0] DEFAULT_COMPARE = 32'd1000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] address,
   input  logic [31:0] writeData,
   input  logic        memoryWriteEnable,
   input  logic        isReturn,
   output logic [31:0] readData,
   output logic        timerInterrupt
);

   typedef enum logic [1:0] {
      REG_CONTROL = 2'd0,
      REG_COUNT   = 2'd1,
      REG_COMPARE = 2'd2,
      REG_STATUS  = 2'd3
   } reg_sel_e;

   logic        enable_q,    enable_d;
   logic        autoReload_q, autoReload_d;
   logic [31:0] count_q,     count_d;
   logic [31:0] compare_q,   compare_d;
   logic        pending_q,   pending_d;
   logic        inHandler_q, inHandler_d;
   logic        irq_q,       irq_d;

   logic     hit;
   logic     wr;
   reg_sel_e sel;
   logic     match;
   logic     fire;
   logic     unused_addr_bits;

   assign hit   = (address[31:4] == BASE_ADDRESS[31:4]);
   assign sel   = reg_sel_e'(address[3:2]);
   assign wr    = hit && memoryWriteEnable;
   assign match = enable_q && (count_q == compare_q);
   // A return in the same cycle defers the fire by one cycle instead of
   // dropping it: inHandler clears first, the pulse follows next edge.
   assign fire  = pending_q && !inHandler_q && !isReturn;

   assign unused_addr_bits = ^address[1:0];

   always_comb begin
      enable_d     = enable_q;
      autoReload_d = autoReload_q;
      count_d      = count_q;
      compare_d    = compare_q;
      pending_d    = pending_q;
      inHandler_d  = inHandler_q;
      irq_d        = fire;

      if (enable_q) begin
         count_d = (match && autoReload_q) ? '0 : count_q + 32'd1;
      end

      if (fire) begin
         pending_d   = 1'b0;
         inHandler_d = 1'b1;
      end else if (isReturn && inHandler_q) begin
         inHandler_d = 1'b0;
      end

      if (wr) begin
         case (sel)
            REG_CONTROL: begin
               enable_d     = writeData[0];
               autoReload_d = writeData[1];
            end
            REG_COUNT:   count_d   = writeData;
            REG_COMPARE: compare_d = writeData;
            REG_STATUS:  if (writeData[0]) pending_d = 1'b0;
            default: ;
         endcase
      end

      // Applied last so a match beats both the W1C clear and the fire clear.
      if (match) begin
         pending_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         enable_q     <= 1'b0;
         autoReload_q <= 1'b0;
         count_q      <= '0;
         compare_q    <= DEFAULT_COMPARE;
         pending_q    <= 1'b0;
         inHandler_q  <= 1'b0;
         irq_q        <= 1'b0;
      end else begin
         enable_q     <= enable_d;
         autoReload_q <= autoReload_d;
         count_q      <= count_d;
         compare_q    <= compare_d;
         pending_q    <= pending_d;
         inHandler_q  <= inHandler_d;
         irq_q        <= irq_d;
      end
   end

   always_comb begin
      readData = '0;
      if (hit) begin
         case (sel)
            REG_CONTROL: readData = {30'd0, autoReload_q, enable_q};
            REG_COUNT:   readData = count_q;
            REG_COMPARE: readData = compare_q;
            REG_STATUS:  readData = {30'd0, inHandler_q, pending_q};
            default:     readData = '0;
         endcase
      end
   end

   assign timerInterrupt = irq_q;

endmodule

// File: tb/tb_preemption_timer.sv
// -----------------------------------------------------------------------------
// tb_preemption_timer
//   Directed bench for preemption_timer. The stimulus process pushes the
//   expected pulse cycles and expected load data into queues; a monitor
//   process compares them against timerInterrupt / readData on the falling
//   edge. Cycle numbers count rising edges; "interval c" is the time between
//   rising edge c and c+1.
// -----------------------------------------------------------------------------
module tb_preemption_timer;

   localparam logic [31:0] BASE   = 32'hFFFF_0100;
   localparam logic [31:0] A_CTRL = BASE + 32'h0;
   localparam logic [31:0] A_CNT  = BASE + 32'h4;
   localparam logic [31:0] A_CMP  = BASE + 32'h8;
   localparam logic [31:0] A_STAT = BASE + 32'hC;
   localparam logic [31:0] A_OUT  = BASE + 32'h10;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] address;
   logic [31:0] writeData;
   logic        memoryWriteEnable;
   logic        isReturn;
   logic [31:0] readData;
   logic        timerInterrupt;

   int unsigned cyc = 0;
   int          checks = 0;
   int          errors = 0;
   bit          rd_req = 1'b0;
   bit          done   = 1'b0;

   int unsigned pulse_q[$];
   logic [31:0] rd_exp_q[$];
   string       rd_name_q[$];

   preemption_timer #(
      .BASE_ADDRESS   (32'hFFFF_0100),
      .DEFAULT_COMPARE(32'd1000)
   ) dut (
      .clk              (clk),
      .reset            (reset),
      .address          (address),
      .writeData        (writeData),
      .memoryWriteEnable(memoryWriteEnable),
      .isReturn         (isReturn),
      .readData         (readData),
      .timerInterrupt   (timerInterrupt)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------------------------------------------------------- helpers
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_to(input int unsigned t);
      while (cyc < t) tick();
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      address           = a;
      writeData         = d;
      memoryWriteEnable = 1'b1;
      tick();
      memoryWriteEnable = 1'b0;
   endtask

   task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string name);
      address = a;
      rd_exp_q.push_back(exp);
      rd_name_q.push_back(name);
      rd_req = 1'b1;
      tick();
      rd_req = 1'b0;
   endtask

   task automatic ret();
      isReturn = 1'b1;
      tick();
      isReturn = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   // ---------------------------------------------------------------- monitor
   initial begin
      forever begin
         @(negedge clk);
         if (timerInterrupt) begin
            checks++;
            if (pulse_q.size() > 0 && pulse_q[0] == cyc) begin
               void'(pulse_q.pop_front());
            end else begin
               errors++;
               $display("FAIL pulse_spurious: timerInterrupt=1 at cycle %0d, required 0 (next expected %0d)",
                        cyc, (pulse_q.size() > 0) ? pulse_q[0] : 0);
            end
         end else if (pulse_q.size() > 0 && pulse_q[0] == cyc) begin
            checks++;
            errors++;
            $display("FAIL pulse_missing: timerInterrupt=0 at cycle %0d, required 1", cyc);
            void'(pulse_q.pop_front());
         end

         if (rd_req && rd_exp_q.size() > 0) begin
            logic [31:0] exp;
            string       nm;
            exp = rd_exp_q.pop_front();
            nm  = rd_name_q.pop_front();
            checks++;
            if (readData !== exp) begin
               errors++;
               $display("FAIL %s: readData=0x%08h at cycle %0d, required 0x%08h", nm, readData, cyc, exp);
            end
         end

         if (done) begin
            checks++;
            if (pulse_q.size() != 0) begin
               errors++;
               $display("FAIL pulse_outstanding: %0d expected pulses never seen, required 0", pulse_q.size());
            end
            $display("Simulation finished: %0d checks, %0d errors", checks, errors);
            $finish;
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete, required completion");
      $fatal(1, "watchdog expired");
   end

   // --------------------------------------------------------------- stimulus
   initial begin
      int unsigned t0;
      int unsigned c;

      reset             = 1'b1;
      address           = '0;
      writeData         = '0;
      memoryWriteEnable = 1'b0;
      isReturn          = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rd(A_CMP, 32'd1000, "reset_compare");
      reset = 1'b0;
      rd(A_CTRL,  32'd0, "reset_control");
      rd(A_CNT,   32'd0, "reset_count");
      rd(A_STAT,  32'd0, "reset_status");

      // Auto-reload, COMPARE=4: period 5, pulse two cycles after the match.
      wr(A_CMP, 32'd4);
      wr(A_CTRL, 32'd3);
      t0 = cyc;
      pulse_q.push_back(t0 + 6);
      for (int i = 0; i < 5; i++) rd(A_CNT, 32'(i), "reload_count");
      rd(A_STAT, 32'd1, "pending_after_match");
      rd(A_STAT, 32'd2, "inhandler_after_fire");
      // Handler held: later matches collapse into one pending request.
      idle_to(t0 + 27);
      rd(A_STAT, 32'd3, "masked_status");
      idle_to(t0 + 30);
      c = cyc;
      pulse_q.push_back(c + 2);
      ret();
      rd(A_STAT, 32'd1, "after_return");
      rd(A_STAT, 32'd2, "refire_status");
      do_reset();

      // No reload, COMPARE=3: one pulse, counter keeps running.
      wr(A_CMP, 32'd3);
      wr(A_CTRL, 32'd1);
      t0 = cyc;
      pulse_q.push_back(t0 + 5);
      for (int i = 0; i < 8; i++) rd(A_CNT, 32'(i), "noreload_count");
      rd(A_STAT, 32'd2, "noreload_inhandler");
      ret();
      rd(A_STAT, 32'd0, "noreload_returned");
      idle_to(t0 + 20);
      c = cyc;
      pulse_q.push_back(c + 4);
      wr(A_CNT, 32'd2);
      rd(A_CNT, 32'd2, "count_written");
      rd(A_CNT, 32'd3, "count_after_write");
      rd(A_STAT, 32'd1, "rematch_pending");
      idle_to(c + 6);
      do_reset();

      // W1C on STATUS racing a match: set wins.
      wr(A_CMP, 32'd5);
      wr(A_CTRL, 32'd3);
      t0 = cyc;
      pulse_q.push_back(t0 + 7);
      idle_to(t0 + 5);
      wr(A_STAT, 32'd1);
      rd(A_STAT, 32'd1, "set_wins");
      idle_to(t0 + 12);
      rd(A_STAT, 32'd3, "pending_in_handler");
      wr(A_STAT, 32'd1);
      rd(A_STAT, 32'd2, "w1c_clears");
      wr(A_CTRL, 32'd0);
      ret();
      rd(A_STAT, 32'd0, "status_idle");
      rd(A_CNT,  32'd4, "count_frozen_a");
      rd(A_CNT,  32'd4, "count_frozen_b");

      // Decode: COMPARE readback, ignored low bits, out-of-window access.
      rd(A_CMP, 32'd5, "compare_read");
      wr(A_CMP, 32'd9);
      rd(A_CMP + 32'd3, 32'd9, "low_bits_ignored");
      rd(A_OUT, 32'd0, "outside_read");
      wr(A_OUT, 32'hFFFF_FFFF);
      rd(A_CTRL, 32'd0, "outside_write_ctrl");
      rd(A_CMP,  32'd9, "outside_write_cmp");
      rd(A_CNT,  32'd4, "outside_write_cnt");
      rd(A_STAT, 32'd0, "outside_write_stat");
      idle_to(cyc + 5);
      do_reset();

      // Asynchronous reset while inHandler=1 and pending=1.
      wr(A_CMP, 32'd2);
      wr(A_CTRL, 32'd3);
      t0 = cyc;
      pulse_q.push_back(t0 + 4);
      idle_to(t0 + 7);
      rd(A_STAT, 32'd3, "pre_reset_status");
      reset = 1'b1;
      rd(A_STAT, 32'd0,    "async_reset_status");
      rd(A_CNT,  32'd0,    "async_reset_count");
      rd(A_CTRL, 32'd0,    "async_reset_control");
      rd(A_CMP,  32'd1000, "async_reset_compare");
      reset = 1'b0;
      repeat (15) tick();
      rd(A_STAT, 32'd0, "post_reset_quiet");

      done = 1'b1;
   end

endmodule
